add_accumulator: RTL

Sequential accumulation stage placed directly downstream of the ADD datapath component. Accepts a stream of DATAWIDTH-bit unsigned sums from ADD's `out` through a valid/ready handshake. Accumulates a fixed number of samples per frame, then presents the frame total with an overflow flag until the consumer takes it. Provides the registered, flow-controlled boundary the combinational adder lacks.

---
 rtl/add_accumulator.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/add_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : add_accumulator
// Description : Registered, flow-controlled accumulation stage placed after
//               the combinational ADD datapath. Sums COUNT unsigned samples
//               per frame. It then holds the frame total and a sticky
//               overflow flag until the consumer takes them.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DATAWIDTH  width of d and q (matches ADD's DATAWIDTH)
//   COUNT      samples per frame, 1 to 256
// Ports
//   Clk        in   rising-edge clock
//   Rst        in   asynchronous active-low reset
//   clr        in   synchronous frame abort, active-high, highest priority
//   d          in   sample from ADD out
//   in_valid   in   d is valid
//   in_ready   out  stage can accept d this cycle
//   q          out  accumulator register; frame total while out_valid
//   ovf        out  sticky carry-out flag for the current frame
//   out_valid  out  q holds a completed frame total
//   out_ready  in   consumer takes q
//   busy       out  a frame is in progress or held
// Configuration macro
//   ADD_ACCUM_SATURATE_EN  when defined, a carry clamps the accumulator to
//                          all-ones for the rest of the frame; when undefined
//                          the sum wraps modulo 2^DATAWIDTH
// ============================================================================
module add_accumulator #(
    parameter int DATAWIDTH = 8,
    parameter int COUNT     = 4
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 clr,
    input  logic [DATAWIDTH-1:0] d,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DATAWIDTH-1:0] q,
    output logic                 ovf,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy
);

    // Counter must be able to hold COUNT itself.
    localparam int                c_cnt_w    = $clog2(COUNT + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(COUNT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [DATAWIDTH-1:0] r_acc;
    logic [DATAWIDTH-1:0] w_acc_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic                 r_ovf;
    logic                 w_ovf_nxt;

    logic                 w_accept;
    logic [DATAWIDTH:0]   w_sum;
    logic                 w_carry;
    logic [DATAWIDTH-1:0] w_add_res;

    // in_ready depends only on registered state and clr, so it can never form
    // a combinational loop through the producer's valid.
    assign in_ready  = (r_state != HOLD) && !clr;
    assign out_valid = (r_state == HOLD);
    assign busy      = (r_state != IDLE);
    assign q         = r_acc;
    assign ovf       = r_ovf;

    assign w_accept  = in_valid && in_ready;

    // One extra bit captures the carry out of the DATAWIDTH-bit add.
    assign w_sum     = {1'b0, r_acc} + {1'b0, d};
    assign w_carry   = w_sum[DATAWIDTH];

`ifdef ADD_ACCUM_SATURATE_EN
    // Once clamped, any later add carries again (or adds zero), so the
    // accumulator stays at all-ones for the rest of the frame.
    assign w_add_res = w_carry ? {DATAWIDTH{1'b1}} : w_sum[DATAWIDTH-1:0];
`else
    assign w_add_res = w_sum[DATAWIDTH-1:0];
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_ovf_nxt   = r_ovf;

        if (clr) begin
            // Abort wins over accept and transfer; in_ready is already low.
            w_state_nxt = IDLE;
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
            w_ovf_nxt   = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        w_acc_nxt   = d;
                        w_ovf_nxt   = 1'b0;
                        w_cnt_nxt   = c_cnt_one;
                        w_state_nxt = (COUNT == 1) ? HOLD : ACCUM;
                    end
                end
                ACCUM: begin
                    if (w_accept) begin
                        w_acc_nxt = w_add_res;
                        w_ovf_nxt = r_ovf | w_carry;
                        w_cnt_nxt = r_cnt + c_cnt_one;
                        if (r_cnt == c_cnt_last) begin
                            w_state_nxt = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        w_state_nxt = IDLE;
                        w_acc_nxt   = '0;
                        w_cnt_nxt   = '0;
                        w_ovf_nxt   = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_acc_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_ovf_nxt   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_acc <= w_acc_nxt;
            r_cnt <= w_cnt_nxt;
            r_ovf <= w_ovf_nxt;
        end
    end

endmodule
`default_nettype wire
